// File: rtl/imem_dmem_rd_arbiter_if.sv
// imem_dmem_rd_arbiter_if: fetch/load AR+R channels and the shared memory read port.
// slave is the arbiter's view; master is the view of the surrounding core and memory.
interface imem_dmem_rd_arbiter_if;
    logic [31:0] s0_araddr;
    logic [2:0]  s0_arprot;
    logic        s0_arvalid;
    logic        s0_arready;
    logic        s0_rvalid;
    logic        s0_rready;
    logic [31:0] s1_araddr;
    logic [2:0]  s1_arprot;
    logic        s1_arvalid;
    logic        s1_arready;
    logic        s1_rvalid;
    logic        s1_rready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic [31:0] m_araddr;
    logic [2:0]  m_arprot;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;

    modport slave (
        input  s0_araddr, s0_arprot, s0_arvalid, s0_rready,
        input  s1_araddr, s1_arprot, s1_arvalid, s1_rready,
        input  m_arready, m_rdata, m_rresp, m_rvalid,
        output s0_arready, s0_rvalid, s1_arready, s1_rvalid,
        output s_rdata, s_rresp,
        output m_araddr, m_arprot, m_arvalid, m_rready
    );

    modport master (
        output s0_araddr, s0_arprot, s0_arvalid, s0_rready,
        output s1_araddr, s1_arprot, s1_arvalid, s1_rready,
        output m_arready, m_rdata, m_rresp, m_rvalid,
        input  s0_arready, s0_rvalid, s1_arready, s1_rvalid,
        input  s_rdata, s_rresp,
        input  m_araddr, m_arprot, m_arvalid, m_rready
    );
endinterface

// File: rtl/imem_dmem_rd_arbiter.sv
// imem_dmem_rd_arbiter: 2:1 AXI4-Lite read arbiter (fetch/load) with in-order response steering.
// Define IMEM_ARB_ROUND_ROBIN_EN for round-robin grants; default is fixed priority, load over fetch.
module imem_dmem_rd_arbiter #(
    parameter int MAX_OUTSTANDING = 2
) (
    input logic clk,
    input logic reset,
    imem_dmem_rd_arbiter_if.slave bus
);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e        state_q;
    logic          lock_id_q;
    logic          id_q [MAX_OUTSTANDING];
    logic [PW-1:0] rptr_q, wptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full, empty, win, gnt_id, ar_valid, push, pop, head, rready;

`ifdef IMEM_ARB_ROUND_ROBIN_EN
    logic last_grant_q;
    always_ff @(posedge clk or posedge reset)
        if (reset) last_grant_q <= 1'b0;
        else if (push) last_grant_q <= gnt_id;
    assign win = (bus.s0_arvalid && bus.s1_arvalid) ? ~last_grant_q : bus.s1_arvalid;
`else
    assign win = bus.s1_arvalid;
`endif

    always_comb begin
        full     = cnt_q == CW'(MAX_OUTSTANDING);
        empty    = cnt_q == '0;
        gnt_id   = (state_q == LOCKED) ? lock_id_q : win;
        ar_valid = (state_q == LOCKED) || (!full && (bus.s0_arvalid || bus.s1_arvalid));
        push     = ar_valid && bus.m_arready;
        head     = id_q[rptr_q];
        rready   = !empty && (head ? bus.s1_rready : bus.s0_rready);
        pop      = rready && bus.m_rvalid;
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
    end

    assign bus.m_arvalid  = ar_valid;
    assign bus.m_araddr   = !ar_valid ? '0 : gnt_id ? bus.s1_araddr : bus.s0_araddr;
    assign bus.m_arprot   = !ar_valid ? '0 : gnt_id ? bus.s1_arprot : bus.s0_arprot;
    assign bus.s0_arready = push && !gnt_id;
    assign bus.s1_arready = push && gnt_id;
    assign bus.s0_rvalid  = !empty && !head && bus.m_rvalid;
    assign bus.s1_rvalid  = !empty && head && bus.m_rvalid;
    assign bus.m_rready   = rready;
    assign bus.s_rdata    = bus.m_rdata;
    assign bus.s_rresp    = bus.m_rresp;

    // A stalled grant stays LOCKED on the same ID so the address cannot change mid-handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            lock_id_q <= 1'b0;
            rptr_q    <= '0;
            wptr_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= (ar_valid && !bus.m_arready) ? LOCKED : IDLE;
            lock_id_q <= gnt_id;
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop) rptr_q <= rptr_q + PW'(1);
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk)
        if (push) id_q[wptr_q] <= gnt_id;
endmodule

// File: tb/tb_imem_dmem_rd_arbiter.sv
// tb_imem_dmem_rd_arbiter: vector table for AR grant decisions plus scoreboarded read sequences.
// Expected R routing is queued at each AR handshake and checked as responses are returned.
module tb_imem_dmem_rd_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    imem_dmem_rd_arbiter_if bus();
    imem_dmem_rd_arbiter #(.MAX_OUTSTANDING(2)) dut (.clk(clk), .reset(reset), .bus(bus));

`ifdef IMEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        logic v0, v1, mar;
        logic mv;
        logic [31:0] addr;
        logic s0r, s1r;
    } vec_t;

    vec_t tbl [7];
    int   n_vec = 0;
    int   n_bad = 0;
    logic sb [$];
    logic last = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, v1, mar, rv, input logic [31:0] rd,
                         input logic [1:0] rr, input logic r0, r1);
        bus.s0_arvalid = v0;
        bus.s1_arvalid = v1;
        bus.m_arready  = mar;
        bus.m_rvalid   = rv;
        bus.m_rdata    = rd;
        bus.m_rresp    = rr;
        bus.s0_rready  = r0;
        bus.s1_rready  = r1;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic model_win(input logic v0, v1);
        return (v0 && v1) ? (RR ? ~last : 1'b1) : v1;
    endfunction

    task automatic ar_check(input string name, input logic exp_v, input logic p);
        logic        hs;
        logic [31:0] a;
        logic [2:0]  pr;
        hs = exp_v && bus.m_arready;
        a  = !exp_v ? 32'h0 : p ? bus.s1_araddr : bus.s0_araddr;
        pr = !exp_v ? 3'h0 : p ? bus.s1_arprot : bus.s0_arprot;
        chk(name, {bus.m_arvalid, bus.m_araddr, bus.m_arprot, bus.s0_arready, bus.s1_arready},
                  {exp_v, a, pr, hs && !p, hs && p});
        if (hs) begin
            sb.push_back(p);
            last = p;
        end
    endtask

    task automatic r_check(input string name, input logic [31:0] d, input logic [1:0] r);
        logic p;
        if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: response with no expected entry, rvalid %b/%b", name,
                     bus.s0_rvalid, bus.s1_rvalid);
        end else begin
            p = sb.pop_front();
            chk(name, {bus.s0_rvalid, bus.s1_rvalid, bus.m_rready, bus.s_rdata, bus.s_rresp},
                      {!p, p, 1'b1, d, r});
        end
    endtask

    task automatic ar_cyc(input string name, input logic v0, v1);
        logic w;
        w = model_win(v0, v1);
        drive(v0, v1, 1'b1, 1'b0, 32'h0, 2'h0, 1'b1, 1'b1);
        @(negedge clk);
        ar_check(name, v0 || v1, w);
        step();
    endtask

    task automatic r_cyc(input string name, input logic [31:0] d, input logic [1:0] r);
        drive(1'b0, 1'b0, 1'b0, 1'b1, d, r, 1'b1, 1'b1);
        @(negedge clk);
        r_check(name, d, r);
        step();
    endtask

    task automatic do_reset;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'h0, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        sb.delete();
        last = 1'b0;
    endtask

    initial begin
        logic w;
        tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h1000, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h2000, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h2000, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h1000, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h2000, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h2000, 1'b0, 1'b0};
        bus.s0_arprot = 3'b100;
        bus.s1_arprot = 3'b001;
        bus.s0_araddr = 32'h1000;
        bus.s1_araddr = 32'h2000;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD, 2'h0, 1'b1, 1'b1);
        @(negedge clk);
        chk("reset_out", {bus.m_arvalid, bus.m_araddr, bus.m_arprot, bus.s0_arready,
                          bus.s1_arready, bus.s0_rvalid, bus.s1_rvalid, bus.m_rready}, 64'h0);
        step();
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            do_reset();
            drive(tbl[i].v0, tbl[i].v1, tbl[i].mar, 1'b0, 32'h0, 2'h0, 1'b0, 1'b0);
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                {bus.m_arvalid, bus.m_araddr, bus.s0_arready, bus.s1_arready, bus.m_rready},
                {tbl[i].mv, tbl[i].addr, tbl[i].s0r, tbl[i].s1r, 1'b0});
            step();
        end
        do_reset();

        bus.s0_araddr = 32'h0;
        ar_cyc("a_ar", 1'b1, 1'b0);
        r_cyc("a_r", 32'h13, 2'h0);

        bus.s0_araddr = 32'h1000;
        w = model_win(1'b1, 1'b1);
        ar_cyc("b_both", 1'b1, 1'b1);
        ar_cyc("b_loser", w, !w);
        r_cyc("b_r0", 32'hB0, 2'h0);
        r_cyc("b_r1", 32'hB1, 2'h0);
        for (int k = 0; k < 2; k++) begin
            ar_cyc($sformatf("b_pair%0d_a", k), 1'b1, 1'b1);
            ar_cyc($sformatf("b_pair%0d_b", k), 1'b1, 1'b1);
            r_cyc($sformatf("b_pair%0d_r0", k), 32'hC0 + k, 2'h0);
            r_cyc($sformatf("b_pair%0d_r1", k), 32'hD0 + k, 2'h0);
        end

        bus.s0_araddr = 32'h3000;
        bus.s1_araddr = 32'h4000;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2'h0, 1'b1, 1'b1);
        @(negedge clk);
        ar_check("c_lock0", 1'b1, 1'b0);
        step();
        for (int k = 1; k < 3; k++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 2'h0, 1'b1, 1'b1);
            @(negedge clk);
            ar_check($sformatf("c_lock%0d", k), 1'b1, 1'b0);
            step();
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 2'h0, 1'b1, 1'b1);
        @(negedge clk);
        ar_check("c_hs0", 1'b1, 1'b0);
        step();
        ar_cyc("c_s1", 1'b0, 1'b1);
        r_cyc("c_r0", 32'h30, 2'h0);
        r_cyc("c_r1", 32'h40, 2'h0);

        ar_cyc("d_ar0", 1'b1, 1'b0);
        ar_cyc("d_ar1", 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 2'h0, 1'b1, 1'b1);
        @(negedge clk);
        ar_check("d_full", 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'hD0, 2'h0, 1'b1, 1'b1);
        @(negedge clk);
        r_check("d_r0", 32'hD0, 2'h0);
        ar_check("d_full_pop", 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 2'h0, 1'b1, 1'b1);
        @(negedge clk);
        ar_check("d_accept", 1'b1, 1'b0);
        step();
        r_cyc("d_r1", 32'hD1, 2'h0);
        r_cyc("d_r2", 32'hD2, 2'h0);

        ar_cyc("e_ar0", 1'b1, 1'b0);
        ar_cyc("e_ar1", 1'b0, 1'b1);
        r_cyc("e_ra", 32'hA, 2'h0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'hB, 2'h2, 1'b1, 1'b0);
        @(negedge clk);
        ar_check("e_ar2", 1'b1, 1'b0);
        chk("e_stall0", {bus.s0_rvalid, bus.s1_rvalid, bus.m_rready, bus.s_rresp},
                        {1'b0, 1'b1, 1'b0, 2'h2});
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hB, 2'h2, 1'b1, 1'b0);
        @(negedge clk);
        chk("e_stall1", {bus.s0_rvalid, bus.s1_rvalid, bus.m_rready}, {1'b0, 1'b1, 1'b0});
        step();
        r_cyc("e_rb", 32'hB, 2'h2);
        r_cyc("e_rc", 32'hC, 2'h0);

        ar_cyc("f_ar0", 1'b1, 1'b0);
        ar_cyc("f_ar1", 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hF, 2'h0, 1'b1, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("f_reset", {bus.m_arvalid, bus.m_araddr, bus.m_arprot, bus.s0_arready,
                        bus.s1_arready, bus.s0_rvalid, bus.s1_rvalid, bus.m_rready}, 64'h0);
        sb.delete();
        last = 1'b0;
        step();
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hF, 2'h0, 1'b1, 1'b1);
        @(negedge clk);
        chk("f_post_rsp", {bus.s0_rvalid, bus.s1_rvalid, bus.m_rready}, 3'b000);
        step();
        ar_cyc("f_ar_after", 1'b1, 1'b0);
        r_cyc("f_r_after", 32'h55, 2'h0);

        chk("sb_drained", 64'(sb.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/imem_dmem_rd_arbiter.md
# imem_dmem_rd_arbiter

Two-to-one AXI4-Lite read-channel arbiter that shares one memory read port between the instruction-fetch master (port 0) and the load/store read master (port 1). It sits between the CPU core and the unified memory/interconnect. It grants read-address requests, tracks up to MAX_OUTSTANDING accepted reads in issue order, and steers each read response back to the master that issued it.

## Interface
- MAX_OUTSTANDING, 2, depth of the in-flight grant-ID queue; power of two, at least 2
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- s0_araddr  in  32  fetch read address
- s0_arprot  in  3  fetch protection bits
- s0_arvalid  in  1  fetch AR valid
- s0_arready  out  1  fetch AR ready
- s0_rvalid  out  1  fetch R valid
- s0_rready  in  1  fetch R ready
- s1_araddr  in  32  load read address
- s1_arprot  in  3  load protection bits
- s1_arvalid  in  1  load AR valid
- s1_arready  out  1  load AR ready
- s1_rvalid  out  1  load R valid
- s1_rready  in  1  load R ready
- s_rdata  out  32  R data, broadcast to both masters; m_rdata passed through
- s_rresp  out  2  R response, broadcast to both masters; m_rresp passed through
- m_araddr  out  32  memory read address
- m_arprot  out  3  memory protection bits
- m_arvalid  out  1  memory AR valid
- m_arready  in  1  memory AR ready
- m_rdata  in  32  memory R data
- m_rresp  in  2  memory R response
- m_rvalid  in  1  memory R valid
- m_rready  out  1  memory R ready

## Operation
- AR grant FSM, two states:
  - IDLE: if the ID queue is not full and any sX_arvalid is high, select a winner combinationally by the priority rule. Drive m_ar* from the winner and set m_arvalid=1. The winner's sX_arready equals m_arready.
  - If m_arready=0, register the winner in lock_id and go to LOCKED.
  - If m_arready=1, push the winner ID into the queue and stay in IDLE.
  - LOCKED: m_ar* comes from lock_id regardless of other requests. Stay in LOCKED until m_arready=1, then push lock_id and return to IDLE. This keeps AXI address stability.
- The queue-full condition blocks new grants in IDLE only. LOCKED is entered only when the queue is not full, so a slot is always available.
- A push and a pop in the same cycle leave the count unchanged.
- The non-granted master sees sX_arready=0.
- Priority with no configuration macro: fixed, port 1 (load) wins over port 0 (fetch).
- R routing:
  - When the queue is non-empty, its head ID selects the master. s{head}_rvalid=m_rvalid, m_rready=s{head}_rready, and the other master sees rvalid=0.
  - m_rvalid && m_rready pops the head.
  - When the queue is empty, both sX_rvalid=0 and m_rready=0.
- Responses are returned strictly in issue order. The block reorders nothing.
- An error response (m_rresp != 0) is forwarded unchanged. The block takes no other action on it.
- Master-side flushes (for example an IF redirect) do not cancel queued IDs. Each issued read still returns its response to its master, and that master discards it.

## Timing
- Zero added latency: the AR and R paths are combinational through the grant mux and queue head. No registers sit in the data paths.
- State: grant state, lock_id, queue storage, read/write pointers, count of log2(MAX_OUTSTANDING)+1 bits. Pointers wrap modulo MAX_OUTSTANDING.
- Outputs after reset, until the first request:
  - m_arvalid=0, m_araddr=0, m_arprot=0.
  - m_rready=0.
  - s0_arready=s1_arready=0.
  - s0_rvalid=s1_rvalid=0.
- Reset state: queue empty, grant state IDLE.
- Reset asserted mid-transaction discards all in-flight IDs. Any memory response arriving after reset is not accepted (m_rready=0 with the queue empty).
- Throughput: one AR per cycle while the queue has space, one R per cycle.

## Configuration
- IMEM_ARB_ROUND_ROBIN_EN defined:
  - A 1-bit last_grant register, reset to 0, updates on each AR handshake.
  - When both ports request in IDLE, the port not equal to last_grant wins.
  - A single requester always wins.
- IMEM_ARB_ROUND_ROBIN_EN undefined: fixed priority, port 1 over port 0. No last_grant register.

## Test plan
- Reset, then s0 alone reads 0x00000000 with m_arready=1 -> m_araddr=0x0, s0_arready=1 in the same cycle. The R beat with rdata=0x00000013 appears only on s0_rvalid.
- s0 and s1 request in the same cycle -> fixed mode: s1 granted, s0 granted next cycle. With the macro: alternates 0,1,0,1 over four back-to-back pairs.
- s0 granted with m_arready held 0 for 3 cycles while s1 raises arvalid -> m_araddr stays at the s0 address. s1 is granted the cycle after the s0 handshake.
- Issue MAX_OUTSTANDING=2 reads with rvalid withheld -> arready stays 0 for a third request. It is accepted in the cycle after the first R handshake.
- Interleaved s0, s1, s0 reads, then responses 0xA, 0xB, 0xC with rresp=2 on the second -> 0xA to s0, 0xB with SLVERR to s1, 0xC to s0. Stall s1_rready for 2 cycles -> m_rready=0 for those cycles.
- Reset asserted with 2 reads outstanding -> all outputs return to the reset values and the next m_rvalid is not accepted.
